// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches one-clock event pulses into wide output pulses
// Events arriving during a pulse or gap are queued in a saturating pending counter.
module pulse_stretcher #(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int CNT_W       = 8,
   parameter int PEND_W      = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_pulse,
   output logic              o_pulse,
   output logic              o_busy,
   output logic [PEND_W-1:0] o_pending,
   output logic              o_overflow
);

   typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

   localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

   state_t             state, state_next;
   logic [CNT_W-1:0]   timer, timer_next;
   logic [PEND_W-1:0]  pending, pending_next;
   logic               gap_end;
   logic               drop;

   always_comb begin
      state_next   = state;
      timer_next   = timer;
      pending_next = pending;
      drop         = 1'b0;
      gap_end      = (state == GAP) && (timer == '0);

      case (state)
         IDLE: begin
            if (i_pulse) begin
               state_next = HIGH;
               timer_next = HOLD_LOAD;
            end
         end
         HIGH: begin
            if (timer == '0) begin
               state_next = GAP;
               timer_next = GAP_LOAD;
            end else begin
               timer_next = timer - CNT_W'(1);
            end
         end
         GAP: begin
            if (timer == '0) begin
               if ((pending != '0) || i_pulse) begin
                  state_next = HIGH;
                  timer_next = HOLD_LOAD;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               timer_next = timer - CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            timer_next = '0;
         end
      endcase

      // At the gap-end edge an incoming event replaces the dequeued one.
      if ((state != IDLE) && !gap_end && i_pulse) begin
         if (pending == PEND_MAX) drop = 1'b1;
         else                     pending_next = pending + PEND_W'(1);
      end else if (gap_end && (pending != '0) && !i_pulse) begin
         pending_next = pending - PEND_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         timer      <= '0;
         pending    <= '0;
         o_pulse    <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         state      <= state_next;
         timer      <= timer_next;
         pending    <= pending_next;
         o_pulse    <= (state_next == HIGH);
         o_overflow <= drop;
      end
   end

   assign o_busy    = (state != IDLE);
   assign o_pending = pending;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - directed self-checking bench for pulse_stretcher
module tb_pulse_stretcher;

   logic       clock;
   logic       reset;
   logic       i_pulse;
   logic       o_pulse;
   logic       o_busy;
   logic [1:0] o_pending;
   logic       o_overflow;

   int errors = 0;
   int checks = 0;

   pulse_stretcher #(
      .HOLD_CYCLES(4),
      .GAP_CYCLES (2),
      .CNT_W      (8),
      .PEND_W     (2)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .i_pulse   (i_pulse),
      .o_pulse   (o_pulse),
      .o_busy    (o_busy),
      .o_pending (o_pending),
      .o_overflow(o_overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Each character is one cycle: input driven before edge i, outputs expected after edge i.
   task automatic run(input string name, input string in_s, input string pul_s,
                      input string busy_s, input string pend_s, input string ovf_s);
      for (int i = 0; i < in_s.len(); i++) begin
         i_pulse = (in_s[i] == "1");
         @(posedge clock);
         #1;
         check($sformatf("%s[%0d].pulse", name, i),    int'(o_pulse),    int'(pul_s[i] - "0"));
         check($sformatf("%s[%0d].busy", name, i),     int'(o_busy),     int'(busy_s[i] - "0"));
         check($sformatf("%s[%0d].pending", name, i),  int'(o_pending),  int'(pend_s[i] - "0"));
         check($sformatf("%s[%0d].overflow", name, i), int'(o_overflow), int'(ovf_s[i] - "0"));
      end
      i_pulse = 1'b0;
   endtask

   initial begin
      reset   = 1'b0;
      i_pulse = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("reset.pulse",    int'(o_pulse),    0);
      check("reset.busy",     int'(o_busy),     0);
      check("reset.pending",  int'(o_pending),  0);
      check("reset.overflow", int'(o_overflow), 0);
      reset = 1'b1;
      @(posedge clock);
      #1;

      run("single", "10000000",
                    "11110000",
                    "11111100",
                    "00000000",
                    "00000000");

      run("queue3", "1100010000000000000",
                    "1111001111001111000",
                    "1111111111111111110",
                    "0111121111110000000",
                    "0000000000000000000");

      run("saturate", "11111000000000000000000000",
                      "11110011110011110011110000",
                      "11111111111111111111111100",
                      "01233322222211111100000000",
                      "00001000000000000000000000");

      run("gapend_pend", "11000010000000000000",
                         "11110011110011110000",
                         "11111111111111111100",
                         "01111111111100000000",
                         "00000000000000000000");

      run("gapend_empty", "1000001000000",
                          "1111001111000",
                          "1111111111110",
                          "0000000000000",
                          "0000000000000");

      // Build pending=2 inside HIGH, then reset asynchronously between edges.
      run("pre_reset", "111",
                       "111",
                       "111",
                       "012",
                       "000");
      #2;
      reset = 1'b0;
      #1;
      check("async_reset.pulse",    int'(o_pulse),    0);
      check("async_reset.busy",     int'(o_busy),     0);
      check("async_reset.pending",  int'(o_pending),  0);
      check("async_reset.overflow", int'(o_overflow), 0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      run("post_reset_idle", "000",
                             "000",
                             "000",
                             "000",
                             "000");
      run("post_reset", "10000000",
                        "11110000",
                        "11111100",
                        "00000000",
                        "00000000");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
